// File: rtl/hash_sched_pkg.sv
// Shared definitions for the hash request scheduler: table op encodings,
// status flag bit positions and the scheduler FSM state type.
package hash_sched_pkg;

  // Encoding of the controller's delete_write_read input
  localparam logic [1:0] OP_NOTHING = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_DELETE  = 2'b11;

  // Bit positions inside the 4-bit status word returned by the controller
  localparam int ST_KEY_ALREADY_PRESENT = 0;
  localparam int ST_NO_ELEMENT_FOUND    = 1;
  localparam int ST_NO_WRITE_SPACE      = 2;
  localparam int ST_NO_DELETION_TARGET  = 3;

  localparam int STATUS_W = 4;
  localparam int OP_W     = 2;

  // One table operation in flight: accept, wait for the bucket, fire, report
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts one past the last granted index and
// wraps, so a requester that stays valid is reached within NUM_REQ grants.
// The pointer only moves when the caller actually takes the grant.
module rr_arbiter
  import hash_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  // Find the first valid requester after the pointer, wrapping at NUM_REQ-1
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && req[IDX_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Remember the last taken grant; reset makes requester 0 the first choice
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (advance && grant_any) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/hash_request_scheduler.sv
// Hash request scheduler: shares one hash table controller between NUM_REQ
// requesters. One request is granted round-robin, held through the
// controller's lookup latency, issued for a single cycle, and its result is
// presented on the response port until it is accepted.
// Optional build macro HASH_SCHED_STATS_EN adds saturating operation and
// failure counters (stat_ops_o, stat_fail_o).
module hash_request_scheduler
  import hash_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int KEY_WIDTH     = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int LOOKUP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [2*NUM_REQ-1:0]          req_op_i,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]  req_key_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i,
  output logic [1:0]                    tbl_op_o,
  output logic [KEY_WIDTH-1:0]          tbl_key_o,
  output logic [DATA_WIDTH-1:0]         tbl_data_o,
  input  logic [DATA_WIDTH-1:0]         tbl_read_data_i,
  input  logic [3:0]                    tbl_status_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [3:0]                    rsp_status_o
`ifdef HASH_SCHED_STATS_EN
  ,
  output logic [31:0]                   stat_ops_o,
  output logic [31:0]                   stat_fail_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e state, state_nxt;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  grant_fire;

  logic [OP_W-1:0]       sel_op;
  logic [KEY_WIDTH-1:0]  sel_key;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [OP_W-1:0]       op_p0;
  logic [KEY_WIDTH-1:0]  key_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [IDX_W-1:0]      id_p0;
  logic [3:0]            lookup_cnt;

  logic [DATA_WIDTH-1:0] rsp_data_p1;
  logic [STATUS_W-1:0]   rsp_status_p1;

  // A grant is only taken in IDLE and never in a reset cycle
  assign grant_fire = (state == S_IDLE) && !reset && arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid_i),
    .advance   (grant_fire),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Pick the granted requester's fields out of the packed request buses
  always_comb begin
    sel_op   = req_op_i[int'(arb_idx)*OP_W +: OP_W];
    sel_key  = req_key_i[int'(arb_idx)*KEY_WIDTH +: KEY_WIDTH];
    sel_data = req_data_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an empty op skips the table entirely
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (arb_any) begin
          state_nxt = (sel_op == OP_NOTHING) ? S_RESP : S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_cnt == 4'd0) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs; the table sees a real op only during EXEC
  always_comb begin
    req_ready_o = ((state == S_IDLE) && !reset) ? arb_grant : '0;
    tbl_op_o    = (state == S_EXEC) ? op_p0 : OP_NOTHING;
    rsp_valid_o = (state == S_RESP);
  end

  // Capture the granted request and count down the lookup latency
  always_ff @(posedge clk) begin
    if (reset) begin
      op_p0      <= OP_NOTHING;
      key_p0     <= '0;
      data_p0    <= '0;
      id_p0      <= '0;
      lookup_cnt <= '0;
    end else if (grant_fire) begin
      op_p0      <= sel_op;
      key_p0     <= sel_key;
      data_p0    <= sel_data;
      id_p0      <= arb_idx;
      lookup_cnt <= 4'(LOOKUP_CYCLES - 1);
    end else if ((state == S_LOOKUP) && (lookup_cnt != 4'd0)) begin
      lookup_cnt <= lookup_cnt - 4'd1;
    end
  end

  // Response payload: cleared at grant (covers the empty op), filled at EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data_p1   <= '0;
      rsp_status_p1 <= '0;
    end else if (grant_fire) begin
      rsp_data_p1   <= '0;
      rsp_status_p1 <= '0;
    end else if (state == S_EXEC) begin
      rsp_data_p1   <= tbl_read_data_i;
      rsp_status_p1 <= tbl_status_i;
    end
  end

  assign tbl_key_o    = key_p0;
  assign tbl_data_o   = data_p0;
  assign rsp_id_o     = id_p0;
  assign rsp_data_o   = rsp_data_p1;
  assign rsp_status_o = rsp_status_p1;

`ifdef HASH_SCHED_STATS_EN
  logic [31:0] stat_ops_q;
  logic [31:0] stat_fail_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count issued table ops and those reporting any status flag
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops_q  <= '0;
      stat_fail_q <= '0;
    end else if (state == S_EXEC) begin
      stat_ops_q <= sat_inc(stat_ops_q);
      if (|tbl_status_i) stat_fail_q <= sat_inc(stat_fail_q);
    end
  end

  assign stat_ops_o  = stat_ops_q;
  assign stat_fail_o = stat_fail_q;
`endif

endmodule
